// File: rtl/matrix_pkg.sv
// matrix_pkg: geometry, pixel codes and sequencer state encoding for the 8x8 bicolour matrix
package matrix_pkg;
  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int PIX_W = 2;
  localparam int ROW_W = COLS * PIX_W;
  localparam int FRAME_W = ROWS * ROW_W;
  typedef enum logic [1:0] {PIX_OFF = 2'b00, PIX_G = 2'b01, PIX_R = 2'b10, PIX_Y = 2'b11} pix_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW} seqState_t;
endpackage

// File: rtl/matrix_tick_gen.sv
// matrix_tick_gen: TICK_DIV prescaler with synchronous clear, one-cycle tick every TICK_DIV cycles
module matrix_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clkI,
  input  logic rstI,
  input  logic clrI,
  output logic tickO
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt;
  assign tickO = !clrI && cnt == CW'(TICK_DIV - 1);
  always_ff @(posedge clkI)
    if (rstI || clrI) cnt <= '0;
    else cnt <= tickO ? '0 : cnt + 1'b1;
endmodule

// File: rtl/matrix_frame_sequencer.sv
// matrix_frame_sequencer: frame store plus IDLE/LOAD/SHOW playback of frames 0..len-1 with dwell timing
// Build option MATRIX_SEQ_BLINK_EN adds blinkI, blanking frameO in alternate BLINK_TICKS windows.
module matrix_frame_sequencer
  import matrix_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TICK_DIV = 50000,
  parameter int DWELL_W = 8,
`ifdef MATRIX_SEQ_BLINK_EN
  parameter int BLINK_TICKS = 16,
`endif
  localparam int IW = $clog2(DEPTH)
) (
  input  logic               clkI,
  input  logic               rstI,
`ifdef MATRIX_SEQ_BLINK_EN
  input  logic               blinkI,
`endif
  input  logic               wrValidI,
  output logic               wrReadyO,
  input  logic [IW-1:0]      wrFrameI,
  input  logic [2:0]         wrRowI,
  input  logic [ROW_W-1:0]   wrDataI,
  input  logic               startI,
  input  logic               stopI,
  input  logic               loopI,
  input  logic [IW:0]        lenI,
  input  logic [DWELL_W-1:0] dwellI,
  output logic [FRAME_W-1:0] frameO,
  output logic [IW-1:0]      frameIdxO,
  output logic               busyO,
  output logic               doneO
);
  seqState_t state;
  logic [FRAME_W-1:0] mem [DEPTH];
  logic [FRAME_W-1:0] frameReg;
  logic [IW-1:0] idx;
  logic [IW:0] len;
  logic [DWELL_W-1:0] dwell, dwCnt;
  logic loop, rdyEn, tick, lastIdx, expire;
  matrix_tick_gen #(.TICK_DIV(TICK_DIV)) uTick (
    .clkI(clkI), .rstI(rstI), .clrI(state == S_LOAD), .tickO(tick)
  );
  // The frame being loaded this cycle must not change under the read
  assign wrReadyO = rdyEn && !(state == S_LOAD && wrFrameI == idx);
  assign lastIdx = {1'b0, idx} == len - (IW+1)'(1);
  assign expire = tick && dwCnt == dwell - DWELL_W'(1);
  always_ff @(posedge clkI)
    if (rstI) begin
      state <= S_IDLE;
      frameReg <= '0;
      frameIdxO <= '0;
      busyO <= 1'b0;
      doneO <= 1'b0;
      rdyEn <= 1'b0;
      idx <= '0;
      len <= '0;
      loop <= 1'b0;
      dwell <= '0;
      dwCnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rdyEn <= 1'b1;
      doneO <= 1'b0;
      if (wrValidI && wrReadyO) mem[wrFrameI][FRAME_W-1-ROW_W*int'(wrRowI) -: ROW_W] <= wrDataI;
      if (state != S_IDLE && stopI) begin
        state <= S_IDLE;
        frameReg <= '0;
        frameIdxO <= '0;
        busyO <= 1'b0;
      end else
        case (state)
          S_IDLE:
            if (startI && lenI != '0 && lenI <= (IW+1)'(DEPTH)) begin
              len <= lenI;
              loop <= loopI;
              dwell <= dwellI == '0 ? DWELL_W'(1) : dwellI;
              idx <= '0;
              busyO <= 1'b1;
              state <= S_LOAD;
            end
          S_LOAD: begin
            frameReg <= mem[idx];
            frameIdxO <= idx;
            dwCnt <= '0;
            state <= S_SHOW;
          end
          default:
            if (expire) begin
              dwCnt <= '0;
              idx <= lastIdx ? '0 : idx + IW'(1);
              state <= lastIdx && !loop ? S_IDLE : S_LOAD;
              busyO <= !(lastIdx && !loop);
              doneO <= lastIdx && !loop;
            end else if (tick) dwCnt <= dwCnt + DWELL_W'(1);
        endcase
    end
`ifdef MATRIX_SEQ_BLINK_EN
  localparam int BW = $clog2(BLINK_TICKS) + 1;
  logic [BW-1:0] blinkTk;
  logic blinkPh, blinkWrap;
  assign blinkWrap = blinkTk == BW'(BLINK_TICKS - 1);
  // Phase restarts with every LOAD so each frame opens with a visible window
  always_ff @(posedge clkI)
    if (rstI || state != S_SHOW) begin
      blinkTk <= '0;
      blinkPh <= 1'b0;
    end else if (tick) begin
      blinkTk <= blinkWrap ? '0 : blinkTk + 1'b1;
      blinkPh <= blinkPh ^ blinkWrap;
    end
  assign frameO = blinkI && blinkPh && state == S_SHOW ? '0 : frameReg;
`else
  assign frameO = frameReg;
`endif
endmodule
